// File: rtl/qpsk_diff_mapper_tx.sv
// QPSK transmit mapper: bytes -> dibits -> Gray decode -> (differential) phase -> I/Q held SPS samples.
// Latency: first sample valid one cycle after an input byte is accepted; bytes reload gaplessly.
// Backpressure: output stall (either I or Q not ready) freezes all state; input ready only on the last sample.
module qpsk_diff_mapper_tx #(
  parameter int                 SPS     = 4,
  parameter logic signed [15:0] AMP     = 16'sd11585,
  parameter bit                 DIFF_EN = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  s_axis_data_tdata,
  input  logic        s_axis_data_tvalid,
  output logic        s_axis_data_tready,
  input  logic        s_axis_data_tlast,
  output logic [15:0] m_axis_i_tdata,
  output logic        m_axis_i_tvalid,
  input  logic        m_axis_i_tready,
  output logic [15:0] m_axis_q_tdata,
  output logic        m_axis_q_tvalid,
  input  logic        m_axis_q_tready,
  output logic        m_axis_tlast,
  output logic        busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SPS - 1);

  state_t             state, state_nxt;
  logic [7:0]         byte_r;
  logic               last_r;
  logic [1:0]         dib_idx;
  logic [7:0]         cnt;
  logic [1:0]         p;
  logic signed [15:0] i_r, q_r;

  logic               out_fire, in_fire, final_smp;
  logic [1:0]         p_ref, p_byte, p_dib;

  // Dibit selection, MSB pair first.
  function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    return b[7:6];
      2'd1:    return b[5:4];
      2'd2:    return b[3:2];
      default: return b[1:0];
    endcase
  endfunction

  // Gray decode to quadrant index, then accumulate (differential) or replace (absolute).
  function automatic logic [1:0] next_p(input logic [1:0] base, input logic [1:0] d);
    logic [1:0] k;
    k = {d[1], d[1] ^ d[0]};
    return DIFF_EN ? (base + k) : k;
  endfunction

  // Quadrants 1 and 2 sit left of the Q axis.
  function automatic logic signed [15:0] map_i(input logic [1:0] ph);
    return (ph[1] ^ ph[0]) ? -AMP : AMP;
  endfunction

  // Quadrants 2 and 3 sit below the I axis.
  function automatic logic signed [15:0] map_q(input logic [1:0] ph);
    return ph[1] ? -AMP : AMP;
  endfunction

  assign final_smp = (dib_idx == 2'd3) && (cnt == CNT_LAST);

  // A byte loading right after a tlast byte restarts its differential reference from zero.
  assign p_ref  = (state == RUN && last_r) ? 2'd0 : p;
  assign p_byte = next_p(p_ref, s_axis_data_tdata[7:6]);
  assign p_dib  = next_p(p, dibit_of(byte_r, dib_idx + 2'd1));

  assign m_axis_i_tvalid = (state == RUN);
  assign m_axis_q_tvalid = (state == RUN);
  assign busy            = (state == RUN);
  assign m_axis_i_tdata  = i_r;
  assign m_axis_q_tdata  = q_r;
  assign m_axis_tlast    = (state == RUN) && last_r && final_smp;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, handshakes; input ready in RUN only as the last sample of the byte leaves.
  always_comb begin
    state_nxt          = state;
    s_axis_data_tready = 1'b0;
    out_fire           = (state == RUN) && m_axis_i_tready && m_axis_q_tready;
    case (state)
      IDLE: begin
        s_axis_data_tready = aresetn;
      end
      RUN: begin
        s_axis_data_tready = final_smp && out_fire;
      end
      default: state_nxt = IDLE;
    endcase
    in_fire = s_axis_data_tvalid && s_axis_data_tready;
    if (state == IDLE && in_fire)
      state_nxt = RUN;
    else if (state == RUN && out_fire && final_smp && !in_fire)
      state_nxt = IDLE;
  end

  // Symbol datapath: byte load, per-sample counting, per-symbol phase update.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      byte_r  <= 8'd0;
      last_r  <= 1'b0;
      dib_idx <= 2'd0;
      cnt     <= 8'd0;
      p       <= 2'd0;
      i_r     <= 16'sd0;
      q_r     <= 16'sd0;
    end else if (in_fire) begin
      byte_r  <= s_axis_data_tdata;
      last_r  <= s_axis_data_tlast;
      dib_idx <= 2'd0;
      cnt     <= 8'd0;
      p       <= p_byte;
      i_r     <= map_i(p_byte);
      q_r     <= map_q(p_byte);
    end else if (out_fire) begin
      if (final_smp) begin
        p <= p_ref;
      end else if (cnt == CNT_LAST) begin
        cnt     <= 8'd0;
        dib_idx <= dib_idx + 2'd1;
        p       <= p_dib;
        i_r     <= map_i(p_dib);
        q_r     <= map_q(p_dib);
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_diff_mapper_tx.sv
// Bench for qpsk_diff_mapper_tx: random bytes/backpressure against a phase-arithmetic reference model.
// Main instance SPS=4 differential; a second instance covers SPS=1 absolute mapping.
// Scoreboard queue is filled on input accept and drained by an output monitor.
module tb_qpsk_diff_mapper_tx;

  localparam int SPS = 4;
  localparam int AMP = 11585;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic        last;
  } exp_t;

  logic        aclk, aresetn;
  logic [7:0]  s_dat;
  logic        s_vld, s_rdy, s_last;
  logic [15:0] i_dat, q_dat;
  logic        i_vld, q_vld, i_rdy, q_rdy, m_last, busy;

  logic [7:0]  s1_dat;
  logic        s1_vld, s1_rdy, s1_last;
  logic [15:0] i1_dat, q1_dat;
  logic        i1_vld, q1_vld, m1_last, busy1;

  int   n_vec = 0;
  int   n_bad = 0;
  int   mp    = 0;
  int   run_len = 0;
  int   last_run = 0;
  bit   sink_rand = 0;
  exp_t exp_q[$];

  // Gray code dibit value -> quadrant index (00->0, 01->1, 11->2, 10->3).
  int gray_k [4] = '{0, 1, 3, 2};

  qpsk_diff_mapper_tx #(.SPS(SPS), .AMP(16'sd11585), .DIFF_EN(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_data_tdata(s_dat), .s_axis_data_tvalid(s_vld),
    .s_axis_data_tready(s_rdy), .s_axis_data_tlast(s_last),
    .m_axis_i_tdata(i_dat), .m_axis_i_tvalid(i_vld), .m_axis_i_tready(i_rdy),
    .m_axis_q_tdata(q_dat), .m_axis_q_tvalid(q_vld), .m_axis_q_tready(q_rdy),
    .m_axis_tlast(m_last), .busy(busy)
  );

  qpsk_diff_mapper_tx #(.SPS(1), .AMP(16'sd11585), .DIFF_EN(1'b0)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_data_tdata(s1_dat), .s_axis_data_tvalid(s1_vld),
    .s_axis_data_tready(s1_rdy), .s_axis_data_tlast(s1_last),
    .m_axis_i_tdata(i1_dat), .m_axis_i_tvalid(i1_vld), .m_axis_i_tready(1'b1),
    .m_axis_q_tdata(q1_dat), .m_axis_q_tvalid(q1_vld), .m_axis_q_tready(1'b1),
    .m_axis_tlast(m1_last), .busy(busy1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [15:0] i_of(input int ph);
    return (ph == 1 || ph == 2) ? 16'(-AMP) : 16'(AMP);
  endfunction

  function automatic logic [15:0] q_of(input int ph);
    return (ph >= 2) ? 16'(-AMP) : 16'(AMP);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one symbol per dibit, phase accumulated mod 4, each symbol repeated SPS times.
  task automatic push_byte(input logic [7:0] b, input logic last);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      mp = (mp + gray_k[(b >> (6 - 2 * d)) & 8'h3]) % 4;
      for (int s = 0; s < SPS; s++) begin
        e.i    = i_of(mp);
        e.q    = q_of(mp);
        e.last = last && (d == 3) && (s == SPS - 1);
        exp_q.push_back(e);
      end
    end
    if (last) mp = 0;
  endtask

  // Offer one byte until accepted (bounded); entered and left at posedge+1.
  task automatic send_one(input logic [7:0] b, input logic last);
    int g;
    bit ok;
    s_dat  = b;
    s_last = last;
    s_vld  = 1'b1;
    g  = 0;
    ok = 1'b0;
    while (!ok && g < 500) begin
      @(negedge aclk);
      g++;
      if (s_rdy) ok = 1'b1;
    end
    if (ok) push_byte(b, last);
    else check("accept_timeout", 32'd0, 32'd1);
    @(posedge aclk);
    #1;
    s_vld = 1'b0;
  endtask

  // Wait (bounded) for every expected sample to emerge, then require idle.
  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 3000) begin
      @(negedge aclk);
      g++;
    end
    check("drain_left", exp_q.size(), 0);
    @(negedge aclk);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("vld_after", {31'd0, i_vld}, 32'd0);
    @(posedge aclk);
    #1;
  endtask

  // Sink: random or full readiness on I and Q independently.
  initial begin
    i_rdy = 1'b1;
    q_rdy = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      i_rdy = sink_rand ? (($urandom % 5) != 0) : 1'b1;
      q_rdy = sink_rand ? (($urandom % 5) != 0) : 1'b1;
    end
  end

  // Monitor: compare every transferred sample against the scoreboard; track valid run length.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && i_vld && i_rdy && q_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL extra_sample: got I=%0h Q=%0h with nothing expected", i_dat, q_dat);
        end else begin
          e = exp_q.pop_front();
          check("i_dat", {16'd0, i_dat}, {16'd0, e.i});
          check("q_dat", {16'd0, q_dat}, {16'd0, e.q});
          check("tlast", {31'd0, m_last}, {31'd0, e.last});
          check("q_vld", {31'd0, q_vld}, 32'd1);
        end
      end
      if (i_vld) run_len++;
      else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  initial begin
    aresetn = 1'b0;
    s_vld = 1'b0; s_dat = 8'd0; s_last = 1'b0;
    s1_vld = 1'b0; s1_dat = 8'd0; s1_last = 1'b0;
    #12;
    check("rst_rdy", {31'd0, s_rdy}, 32'd0);
    check("rst_ivld", {31'd0, i_vld}, 32'd0);
    check("rst_qvld", {31'd0, q_vld}, 32'd0);
    check("rst_idat", {16'd0, i_dat}, 32'd0);
    check("rst_qdat", {16'd0, q_dat}, 32'd0);
    check("rst_last", {31'd0, m_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rdy_after_rst", {31'd0, s_rdy}, 32'd1);
    @(posedge aclk);
    #1;

    // Random bytes, random idle gaps and random output backpressure.
    sink_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom % 3) begin
        @(posedge aclk);
        #1;
      end
      send_one(8'($urandom), ($urandom % 4) == 0);
    end
    sink_rand = 1'b0;
    drain();

    // Three bytes back-to-back with full readiness: one unbroken valid run.
    for (int n = 0; n < 3; n++) send_one(8'($urandom), 1'b0);
    drain();
    check("gapless_run", last_run, 3 * 4 * SPS);

    // Two tlast frames of 0x40: each restarts from phase 0.
    send_one(8'h40, 1'b1);
    send_one(8'h40, 1'b1);
    drain();

    // Abort mid-symbol (dibit 1, sample 2) with asynchronous reset.
    send_one(8'hE4, 1'b0);
    repeat (7) @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("abort_ivld", {31'd0, i_vld}, 32'd0);
    check("abort_qvld", {31'd0, q_vld}, 32'd0);
    check("abort_idat", {16'd0, i_dat}, 32'd0);
    check("abort_qdat", {16'd0, q_dat}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdy", {31'd0, s_rdy}, 32'd0);
    exp_q.delete();
    mp = 0;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rel_rdy", {31'd0, s_rdy}, 32'd1);
    check("rel_ivld", {31'd0, i_vld}, 32'd0);
    @(posedge aclk);
    #1;
    send_one(8'h00, 1'b1);
    drain();

    // SPS=1 absolute mapping: 0x1B gives four symbols on consecutive cycles.
    begin
      logic [7:0] b;
      int         g;
      int         ph;
      b = 8'h1B;
      s1_dat  = b;
      s1_last = 1'b1;
      s1_vld  = 1'b1;
      g = 0;
      do begin
        @(negedge aclk);
        g++;
      end while (!s1_rdy && g < 50);
      check("s1_accept", {31'd0, s1_rdy}, 32'd1);
      @(posedge aclk);
      #1;
      s1_vld = 1'b0;
      for (int d = 0; d < 4; d++) begin
        @(negedge aclk);
        ph = gray_k[(b >> (6 - 2 * d)) & 8'h3];
        check("s1_vld", {31'd0, i1_vld}, 32'd1);
        check("s1_i", {16'd0, i1_dat}, {16'd0, i_of(ph)});
        check("s1_q", {16'd0, q1_dat}, {16'd0, q_of(ph)});
        check("s1_last", {31'd0, m1_last}, {31'd0, (d == 3)});
      end
      @(negedge aclk);
      check("s1_idle", {31'd0, i1_vld}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qpsk_diff_mapper_tx.md
Name: qpsk_diff_mapper_tx

Overview:
Transmit-side counterpart of the QPSK Costas carrier-recovery receiver in the same RFNoC costas path. The block accepts a byte stream and splits each byte into dibits. Each dibit is Gray-decoded to a quadrant index, optionally differentially encoded to resolve the receiver's 90° phase ambiguity, and mapped to fixed-amplitude I/Q constellation points. Each symbol is held for SPS samples and emitted on separate I and Q AXI-Stream outputs in sfix16_15, matching the receiver's I/Q input format.

Parameters:
SPS, 4, samples per symbol (1..256); zero-order hold
AMP, 16'sd11585, constellation magnitude per axis, sfix16_15 (~0.354)
DIFF_EN, 1, 1 = differential encoding, 0 = absolute mapping

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_data_tdata  in  8  input byte, MSB dibit transmitted first
s_axis_data_tvalid  in  1  input valid
s_axis_data_tready  out  1  input ready
s_axis_data_tlast  in  1  last byte of frame
m_axis_i_tdata  out  16  I sample, sfix16_15
m_axis_i_tvalid  out  1  I valid
m_axis_i_tready  in  1  I ready
m_axis_q_tdata  out  16  Q sample, sfix16_15
m_axis_q_tvalid  out  1  Q valid, always equal to m_axis_i_tvalid
m_axis_q_tready  in  1  Q ready
m_axis_tlast  out  1  marks last sample of a tlast byte
busy  out  1  high while in RUN

Behaviour:
- Reset (aresetn low, async) clears everything:
  - all tdata outputs = 0; all tvalid outputs, m_axis_tlast, busy = 0
  - s_axis_data_tready = 0 during reset, 1 in the first cycle after release
  - phase state p = 0; dibit index = 0; sample counter = 0; state = IDLE
- An output sample transfers (out_fire) when m_axis_i_tvalid && m_axis_i_tready && m_axis_q_tready. I and Q always advance together; there is no partial transfer.
- An input byte is accepted (in_fire) when s_axis_data_tvalid && s_axis_data_tready.
- State IDLE:
  - s_axis_data_tready = 1
  - on in_fire: latch the byte and its tlast, compute the first symbol, go to RUN
  - the first sample is valid in the next cycle (latency 1 cycle)
- State RUN:
  - the m tvalid signals are held high; tdata and tlast are stable until out_fire
  - on each out_fire, the sample counter increments
  - at count SPS-1, the counter wraps to 0 and the dibit index increments
  - after dibit index 3 wraps, the byte is done
- Gapless reload:
  - s_axis_data_tready = 1 in RUN only when on the final sample of the byte (dibit 3, count SPS-1), combinationally gated by out_fire
  - if in_fire occurs in that cycle, load the next byte's first symbol directly and stay in RUN (no valid bubble)
  - if no in_fire occurs, go to IDLE and deassert the m tvalid signals
- Dibit order: tdata[7:6], [5:4], [3:2], [1:0].
- Gray decode of dibit to quadrant index k: 00→0, 01→1, 11→2, 10→3.
- Phase update (once per symbol, at symbol load):
  - DIFF_EN=1: p ← (p + k) mod 4
  - DIFF_EN=0: p ← k
- Constellation mapping of p to (I, Q):
  - 0 → (+AMP, +AMP)
  - 1 → (−AMP, +AMP)
  - 2 → (−AMP, −AMP)
  - 3 → (+AMP, −AMP)
- −AMP is the exact two's complement of AMP; there is no saturation path.
- m_axis_tlast is high on the final sample (dibit 3, count SPS-1) of a byte latched with tlast=1.
- After that sample transfers, p is reset to 0 so the next frame's differential reference restarts. If a new byte loads in the same cycle, its phase update uses p=0.
- SPS=1: every out_fire advances the dibit; the byte-done condition is the dibit-3 transfer.
- Backpressure of any length freezes all state, with no sample loss or duplication.
- An upstream stall is not filled with padding samples; output valid simply drops.
- Async reset mid-symbol aborts the byte immediately; no sample of it is emitted after release.

Test Plan:
- DIFF_EN=0, SPS=1, byte 0x1B with ready held high -> 4 samples in consecutive cycles:
  - (+11585, +11585), (−11585, +11585), (+11585, −11585), (−11585, −11585)
  - first sample appears 1 cycle after in_fire
- DIFF_EN=1, SPS=4, byte 0x55 -> p = 1, 2, 3, 0, each held 4 samples:
  - (−A,+A)×4, (−A,−A)×4, (+A,−A)×4, (+A,+A)×4
  - s_axis_data_tready pulses once, on sample 16
- Same stimulus with m_axis_q_tready low for 3 cycles at sample 6 -> tdata frozen during the stall; exactly 16 samples transferred; sequence identical.
- Three bytes offered back-to-back with continuous tvalid and ready -> m tvalid continuous for 3×4×SPS cycles with no bubble; busy drops one cycle after the last sample.
- DIFF_EN=1, SPS=2, byte 0x40 with tlast, then 0x40 with tlast:
  - each frame gives p = 1, 1, 1, 1 (the second frame restarts from p=0, not p=2)
  - m_axis_tlast is asserted on samples 8 and 16 only
- aresetn pulsed low mid-symbol (dibit 1, count 2) -> all outputs 0 and tvalid 0 asynchronously; after release, byte 0x00 yields (+A,+A) from p=0.
